pipe5_hazard_ctrl: RTL and testbench

//  Central pipeline controller for pipe5; the responder end of the hazard/forwarding interface.

---
 rtl/pipe5_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pipe5_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe5_hazard_ctrl.sv
// pipe5_hazard_ctrl - central hazard / forwarding controller for the pipe5 core.
//
// Sits between the five pipeline stages and the priv unit. Resolves operand
// bypass for the execute stage, load-use and multicycle-busy stalls, and
// sequences trap entry, xRET return and FENCE drain.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds stall_cycles / flush_events.
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   f_busy, x_busy, m_busy            per-stage multicycle busy
//   rs1_x, rs2_x, rd_x, x_dren        execute-stage sources / dest / load flag
//   rs1_d, rs2_d                      decode-stage sources
//   rd_m, reg_wen_m, rd_w, reg_wen_w  mem / writeback destination + write valid
//   mispredict, exception, ret        mem-stage control-flow events
//   fence_stall                       mem-stage FENCE drain request
//   epc, badaddr, priv_pc             trap state in, trap vector / return PC
//   pc_en, npc_sel, iren              fetch control
//   fd/dx/xm/mw_stall, _flush         pipeline register hold / bubble
//   insert_priv_pc, priv_pc_q         redirect strobe and registered target
//   epc_q, badaddr_q                  captured trap state to priv unit
//   bypass_a, bypass_b                ALU operand select: 0 RF, 1 from M, 2 from W
//   stall_cycles, flush_events        perf counters (HAZARD_PERF_CNT_EN only)
//
// state       | meaning
// RUN         | normal issue; hazards resolved combinationally
// TRAP        | pipeline flushed, trap vector being latched
// REDIRECT    | fetch loads priv_pc_q for exactly one cycle
// FENCE_DRAIN | fetch held until mem stage goes idle or the drain limit hits
module pipe5_hazard_ctrl #(
  parameter int RSEL_W    = 5,
  parameter int WORD_W    = 32,
  parameter int DRAIN_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_busy,
  input  logic              x_busy,
  input  logic              m_busy,
  input  logic [RSEL_W-1:0] rs1_x,
  input  logic [RSEL_W-1:0] rs2_x,
  input  logic [RSEL_W-1:0] rd_x,
  input  logic              x_dren,
  input  logic [RSEL_W-1:0] rs1_d,
  input  logic [RSEL_W-1:0] rs2_d,
  input  logic [RSEL_W-1:0] rd_m,
  input  logic              reg_wen_m,
  input  logic [RSEL_W-1:0] rd_w,
  input  logic              reg_wen_w,
  input  logic              mispredict,
  input  logic              exception,
  input  logic              ret,
  input  logic              fence_stall,
  input  logic [WORD_W-1:0] epc,
  input  logic [WORD_W-1:0] badaddr,
  input  logic [WORD_W-1:0] priv_pc,
  output logic              pc_en,
  output logic              npc_sel,
  output logic              fd_stall,
  output logic              dx_stall,
  output logic              xm_stall,
  output logic              mw_stall,
  output logic              fd_flush,
  output logic              dx_flush,
  output logic              xm_flush,
  output logic              mw_flush,
  output logic              iren,
  output logic              insert_priv_pc,
  output logic [WORD_W-1:0] priv_pc_q,
  output logic [WORD_W-1:0] epc_q,
  output logic [WORD_W-1:0] badaddr_q,
  output logic [1:0]        bypass_a,
  output logic [1:0]        bypass_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_events
`endif
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_MAX);

  typedef enum logic [1:0] {RUN, TRAP, REDIRECT, FENCE_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] drain_inc;
  logic             lu_q;
  logic             load_use;
  logic             trap_take;
  logic             priv_latch;
  logic             drain_clr;
  logic             lu_take;
  logic             mp_take;

  // Forwarding: the mem-stage result is younger than writeback, so it wins.
  always_comb begin
    bypass_a = 2'd0;
    if (reg_wen_m && (rd_m != '0) && (rd_m == rs1_x))      bypass_a = 2'd1;
    else if (reg_wen_w && (rd_w != '0) && (rd_w == rs1_x)) bypass_a = 2'd2;
    bypass_b = 2'd0;
    if (reg_wen_m && (rd_m != '0) && (rd_m == rs2_x))      bypass_b = 2'd1;
    else if (reg_wen_w && (rd_w != '0) && (rd_w == rs2_x)) bypass_b = 2'd2;
  end

  // lu_q blocks a second back-to-back load-use stall for the same load.
  assign load_use = x_dren && (rd_x != '0) && ((rd_x == rs1_d) || (rd_x == rs2_d)) && !lu_q;
  assign drain_inc = drain_cnt + CNT_W'(1);

  always_comb begin
    state_nxt      = state;
    pc_en          = 1'b1;
    npc_sel        = 1'b0;
    iren           = 1'b1;
    insert_priv_pc = 1'b0;
    fd_stall       = 1'b0;
    dx_stall       = 1'b0;
    xm_stall       = 1'b0;
    mw_stall       = 1'b0;
    fd_flush       = 1'b0;
    dx_flush       = 1'b0;
    xm_flush       = 1'b0;
    mw_flush       = 1'b0;
    trap_take      = 1'b0;
    priv_latch     = 1'b0;
    drain_clr      = 1'b0;
    lu_take        = 1'b0;
    mp_take        = 1'b0;
    case (state)
      RUN: begin
        if (exception && !m_busy) begin
          // A busy mem stage has not finished the faulting op; wait for it.
          {fd_flush, dx_flush, xm_flush, mw_flush} = 4'b1111;
          pc_en     = 1'b0;
          trap_take = 1'b1;
          state_nxt = TRAP;
        end else if (ret) begin
          // Return PC is already on priv_pc; latch it for the REDIRECT cycle.
          {fd_flush, dx_flush, xm_flush} = 3'b111;
          priv_latch = 1'b1;
          state_nxt  = REDIRECT;
        end else if (mispredict) begin
          npc_sel  = 1'b1;
          {fd_flush, dx_flush, xm_flush} = 3'b111;
          mp_take  = 1'b1;
        end else if (fence_stall) begin
          pc_en     = 1'b0;
          fd_flush  = 1'b1;
          drain_clr = 1'b1;
          state_nxt = FENCE_DRAIN;
        end else if (load_use) begin
          fd_stall = 1'b1;
          dx_stall = 1'b1;
          xm_flush = 1'b1;
          pc_en    = 1'b0;
          lu_take  = 1'b1;
        end else begin
          // A stalled register cannot also take a bubble from a younger stage.
          mw_stall = m_busy;
          xm_stall = m_busy;
          dx_stall = m_busy | x_busy;
          fd_stall = m_busy | x_busy;
          xm_flush = x_busy & ~m_busy;
          fd_flush = f_busy & ~(m_busy | x_busy);
          pc_en    = ~(m_busy | x_busy | f_busy);
        end
      end
      TRAP: begin
        {fd_flush, dx_flush, xm_flush, mw_flush} = 4'b1111;
        pc_en      = 1'b0;
        iren       = 1'b0;
        priv_latch = 1'b1;
        state_nxt  = REDIRECT;
      end
      REDIRECT: begin
        insert_priv_pc = 1'b1;
        npc_sel        = 1'b1;
        state_nxt      = RUN;
      end
      FENCE_DRAIN: begin
        if (m_busy) begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
        end
        if (!m_busy || (drain_inc >= DRAIN_LIM) || (drain_cnt >= DRAIN_LIM))
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q     <= '0;
      badaddr_q <= '0;
      priv_pc_q <= '0;
      drain_cnt <= '0;
      lu_q      <= 1'b0;
    end else begin
      if (trap_take) begin
        epc_q     <= epc;
        badaddr_q <= badaddr;
      end
      if (priv_latch) priv_pc_q <= priv_pc;
      if (drain_clr)
        drain_cnt <= '0;
      else if ((state == FENCE_DRAIN) && (drain_cnt < DRAIN_LIM))
        drain_cnt <= drain_inc;
      lu_q <= lu_take;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((state == RUN) && !pc_en) stall_cycles <= stall_cycles + 32'd1;
      if ((mp_take || trap_take) && (flush_events != 16'hFFFF))
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe5_hazard_ctrl.sv
module tb_pipe5_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_busy, x_busy, m_busy;
  logic [4:0]  rs1_x, rs2_x, rd_x, rs1_d, rs2_d, rd_m, rd_w;
  logic        x_dren, reg_wen_m, reg_wen_w;
  logic        mispredict, exception, ret, fence_stall;
  logic [31:0] epc, badaddr, priv_pc;
  logic        pc_en, npc_sel, iren, insert_priv_pc;
  logic        fd_stall, dx_stall, xm_stall, mw_stall;
  logic        fd_flush, dx_flush, xm_flush, mw_flush;
  logic [31:0] priv_pc_q, epc_q, badaddr_q;
  logic [1:0]  bypass_a, bypass_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  pipe5_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .f_busy(f_busy), .x_busy(x_busy), .m_busy(m_busy),
    .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .x_dren(x_dren),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_m(rd_m), .reg_wen_m(reg_wen_m), .rd_w(rd_w), .reg_wen_w(reg_wen_w),
    .mispredict(mispredict), .exception(exception), .ret(ret), .fence_stall(fence_stall),
    .epc(epc), .badaddr(badaddr), .priv_pc(priv_pc),
    .pc_en(pc_en), .npc_sel(npc_sel),
    .fd_stall(fd_stall), .dx_stall(dx_stall), .xm_stall(xm_stall), .mw_stall(mw_stall),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush), .mw_flush(mw_flush),
    .iren(iren), .insert_priv_pc(insert_priv_pc), .priv_pc_q(priv_pc_q),
    .epc_q(epc_q), .badaddr_q(badaddr_q),
    .bypass_a(bypass_a), .bypass_b(bypass_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // stall/flush nibbles are ordered {fd, dx, xm, mw}
  typedef struct packed {
    logic       pc_en;
    logic       npc_sel;
    logic [3:0] stall;
    logic [3:0] flush;
    logic       ins;
    logic [1:0] ba;
    logic [1:0] bb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t mk(logic p, logic n, logic [3:0] st, logic [3:0] fl,
                              logic i, logic [1:0] a, logic [1:0] b);
    exp_t e;
    e.pc_en = p; e.npc_sel = n; e.stall = st; e.flush = fl;
    e.ins = i; e.ba = a; e.bb = b;
    return e;
  endfunction

  function automatic exp_t observe();
    return mk(pc_en, npc_sel, {fd_stall, dx_stall, xm_stall, mw_stall},
              {fd_flush, dx_flush, xm_flush, mw_flush}, insert_priv_pc, bypass_a, bypass_b);
  endfunction

  task automatic compare_front(input string tag);
    exp_t ex, ob;
    ex = sb.pop_front();
    ob = observe();
    checks++;
    assert (ob === ex) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, ob, ex);
    end
  endtask

  task automatic expect_now(input exp_t e, input string tag);
    sb.push_back(e);
    compare_front(tag);
  endtask

  // One pipeline cycle: inputs already driven, outputs sampled at negedge.
  task automatic cyc(input exp_t e, input string tag);
    sb.push_back(e);
    @(negedge clk);
    compare_front(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input logic [31:0] ob, input logic [31:0] ex, input string tag);
    checks++;
    assert (ob === ex) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, ob, ex);
    end
  endtask

  task automatic clr();
    f_busy = 0; x_busy = 0; m_busy = 0;
    rs1_x = 0; rs2_x = 0; rd_x = 0; x_dren = 0; rs1_d = 0; rs2_d = 0;
    rd_m = 0; reg_wen_m = 0; rd_w = 0; reg_wen_w = 0;
    mispredict = 0; exception = 0; ret = 0; fence_stall = 0;
    epc = 0; badaddr = 0; priv_pc = 0;
  endtask

  exp_t idle;

  initial begin
    idle = mk(1, 0, 4'h0, 4'h0, 0, 2'd0, 2'd0);
    clr();
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    expect_now(idle, "reset_outputs");
    chk_word({31'd0, iren}, 32'd1, "reset_iren");
    chk_word(epc_q, 32'd0, "reset_epc_q");
    chk_word(priv_pc_q, 32'd0, "reset_priv_pc_q");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc(idle, "idle");

    // bypass selection
    rd_m = 5; reg_wen_m = 1; rd_w = 5; reg_wen_w = 1; rs1_x = 5; rs2_x = 5;
    cyc(mk(1, 0, 0, 0, 0, 2'd1, 2'd1), "byp_m_wins");
    rd_m = 0;
    cyc(mk(1, 0, 0, 0, 0, 2'd2, 2'd2), "byp_rdm_zero");
    rs1_x = 0;
    cyc(mk(1, 0, 0, 0, 0, 2'd0, 2'd2), "byp_rs1_zero");
    rd_m = 5; reg_wen_m = 0; rs1_x = 5; rs2_x = 9;
    cyc(mk(1, 0, 0, 0, 0, 2'd2, 2'd0), "byp_wen_m_off");
    clr();

    // load-use: single-cycle stall even if the condition is held
    x_dren = 1; rd_x = 3; rs2_d = 3;
    cyc(mk(0, 0, 4'hC, 4'h2, 0, 0, 0), "lu_stall");
    cyc(idle, "lu_one_cycle");
    clr();
    x_dren = 1; rd_x = 0; rs1_d = 0;
    cyc(idle, "lu_rd_zero");
    clr();

    // busy stalls
    m_busy = 1; x_busy = 1; f_busy = 1;
    cyc(mk(0, 0, 4'hF, 4'h0, 0, 0, 0), "busy_all");
    m_busy = 0;
    cyc(mk(0, 0, 4'hC, 4'h2, 0, 0, 0), "busy_x_f");
    x_busy = 0;
    cyc(mk(0, 0, 4'h0, 4'h8, 0, 0, 0), "busy_f");
    clr();

    // exception beats mispredict; trap sequence
    epc = 32'h200; badaddr = 32'h44; priv_pc = 32'h80; exception = 1; mispredict = 1;
    cyc(mk(0, 0, 4'h0, 4'hF, 0, 0, 0), "exc_cycle0");
    chk_word(epc_q, 32'h200, "exc_epc_q");
    chk_word(badaddr_q, 32'h44, "exc_badaddr_q");
    mispredict = 0; epc = 32'h300;
    cyc(mk(0, 0, 4'h0, 4'hF, 0, 0, 0), "exc_trap");
    chk_word(priv_pc_q, 32'h80, "exc_priv_pc_q");
    chk_word(epc_q, 32'h200, "exc_epc_held");
    exception = 0;
    cyc(mk(1, 1, 4'h0, 4'h0, 1, 0, 0), "exc_redirect");
    cyc(idle, "exc_back_run");
    clr();

    // xRET
    ret = 1; priv_pc = 32'h1234;
    cyc(mk(1, 0, 4'h0, 4'hE, 0, 0, 0), "ret_cycle0");
    ret = 0; priv_pc = 32'h0;
    cyc(mk(1, 1, 4'h0, 4'h0, 1, 0, 0), "ret_redirect");
    chk_word(priv_pc_q, 32'h1234, "ret_priv_pc_q");

    // mispredict alone
    mispredict = 1;
    cyc(mk(1, 1, 4'h0, 4'hE, 0, 0, 0), "mispredict");
    mispredict = 0;
    cyc(idle, "mispredict_after");

    // fence with mem busy longer than the drain limit
    fence_stall = 1; m_busy = 1;
    cyc(mk(0, 0, 4'h0, 4'h8, 0, 0, 0), "fence_enter");
    fence_stall = 0;
    for (int i = 0; i < 4; i++) cyc(mk(0, 0, 4'h0, 4'h8, 0, 0, 0), "fence_drain");
    cyc(mk(0, 0, 4'hF, 4'h0, 0, 0, 0), "fence_forced_exit");
    m_busy = 0;
    cyc(idle, "fence_idle");
    fence_stall = 1;
    cyc(mk(0, 0, 4'h0, 4'h8, 0, 0, 0), "fence_short_enter");
    fence_stall = 0;
    cyc(idle, "fence_short_exit");
    cyc(idle, "fence_short_run");

    // reset while in TRAP
    exception = 1; epc = 32'h500;
    cyc(mk(0, 0, 4'h0, 4'hF, 0, 0, 0), "rst_exc");
    exception = 0;
    rst_n = 0;
    #1;
    expect_now(idle, "rst_in_trap");
    chk_word(epc_q, 32'd0, "rst_epc_q");
    #1 rst_n = 1;
    cyc(idle, "rst_resume");
    cyc(idle, "rst_no_insert");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
